entry_input_port: RTL and testbench
===================================

Name: entry_input_port

Overview:
- Producer side of the processor's keyed-input interface: debounces the raw "ent" push-button and captures the 16-bit switch word on each confirmed press-release.
- Queues captured words in a small FIFO and presents the head word to the processor with a valid/read handshake.
- The processor's IN instruction consumes one word per read pulse and no longer edge-detects "ent" itself.
- Clocked by the fast board clock, not the divided CPU clock.

Parameters:
WIDTH, 16, switch/data word width
DEPTH, 4, FIFO entries; power of two, >=2
DEBOUNCE_CYCLES, 250000, consecutive stable cycles needed to accept a button level change (5 ms at 50 MHz)

Ports:
clk  input  1  board clock, all logic on posedge
reset  input  1  asynchronous, active-low; clears all state
ent  input  1  raw push-button, active-low (0 = pressed)
switch  input  WIDTH  raw switch word
rd  input  1  processor read/pop pulse, one cycle per word (synchronous to clk)
clr_ovf  input  1  clears overflow flag
data  output  WIDTH  FIFO head word
valid  output  1  FIFO non-empty
count  output  log2(DEPTH)+1  number of stored words
overflow  output  1  sticky: a capture was dropped because the FIFO was full

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low.
- Reset values: data=0, valid=0, count=0, overflow=0, FIFO pointers=0, debouncer state=RELEASED, debounce counter=0, synchronizer flops=1 for ent and 0 for switch.
- Synchronization: ent and switch each pass through a 2-flop synchronizer.
- Debouncer FSM runs on synchronized ent (ent_s); the counter resets to 0 on every state transition and whenever ent_s returns to the current stable level.
  - RELEASED: ent_s=0 -> PRESS_WAIT.
  - PRESS_WAIT: ent_s=1 -> RELEASED. After DEBOUNCE_CYCLES consecutive cycles with ent_s=0 -> PRESSED.
  - PRESSED: ent_s=1 -> RELEASE_WAIT.
  - RELEASE_WAIT: ent_s=0 -> PRESSED. After DEBOUNCE_CYCLES consecutive cycles with ent_s=1 -> RELEASED and assert capture for exactly one cycle.
- Capture latency: the pushed word is the synchronized switch value on the capture cycle.
  - With raw ent rising at edge t and held, valid rises at edge t+DEBOUNCE_CYCLES+3.
  - Glitches shorter than DEBOUNCE_CYCLES cycles never change state.
  - A press shorter than DEBOUNCE_CYCLES cycles never captures.
- FIFO push (on capture):
  - Not full: write at wr_ptr, increment wr_ptr modulo DEPTH, count+1.
  - Full and no pop in the same cycle: word dropped; pointers and count unchanged; overflow<=1.
  - Full with rd=1 in the same cycle: both the pop and the push happen; count stays DEPTH and order is preserved.
- FIFO pop (rd=1 and count!=0): increment rd_ptr modulo DEPTH, count-1. rd while empty is ignored; no state change.
- Push and pop in the same non-empty cycle: count unchanged.
- Outputs:
  - data = mem[rd_ptr], registered-memory read with no extra latency: data updates on the edge after a pop.
  - valid = (count!=0).
  - When empty, data holds the last head value (0 after reset).
- Overflow flag: clr_ovf clears it. A drop in the same cycle as clr_ovf wins (overflow stays 1).
- Pointer width is log2(DEPTH); count is one bit wider so that DEPTH is representable.
- Reset asserted mid-press: state returns to RELEASED.
  - If ent is still held low after reset deasserts, a press is qualified normally and the capture occurs on its later release.
  - A press interrupted by reset is never half-counted.

Decomposition:
- Shared package: debouncer state encoding (RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT), ENT_PRESSED=1'b0 polarity constant, default DEBOUNCE_CYCLES.
- Sub-module ent_debouncer: synchronizer + FSM + counter, outputs a 1-cycle capture pulse.
- FIFO storage and pointers live in the top level.

Test Plan (sim with DEBOUNCE_CYCLES=4, DEPTH=4):
- Reset: pulse reset low while ent=0 -> data=0, valid=0, count=0, overflow=0; releasing ent 2 cycles after reset deasserts then pressing/releasing once -> exactly one word captured.
- Clean entry: switch=16'hABCD, ent low 10 cycles, then high at edge t -> valid=1, data=16'hABCD, count=1 at edge t+7; then rd=1 for 1 cycle -> valid=0, count=0.
- Bounce: ent low 3 cycles, high 2, low 3, high held -> no transition to PRESSED, count stays 0.
- Overflow: 5 clean entries 16'h0001..16'h0005 with no rd -> count=4, data=16'h0001, overflow=1; four reads return 1,2,3,4; clr_ovf -> overflow=0.
- Full plus simultaneous: FIFO holds 1..4, rd=1 on the capture cycle of 16'h0009 -> count=4, overflow=0, subsequent reads return 2,3,4,9.
- Empty read: rd=1 for 3 cycles with count=0 -> count=0, valid=0, pointers unchanged (next capture read back correctly).

Source files
------------

// File: rtl/entry_input_port_pkg.sv
`default_nettype none
// ============================================================================
// entry_input_port_pkg : shared types and constants for the keyed-input port
// Revision: 1.0
// ============================================================================
package entry_input_port_pkg;

    typedef enum logic [1:0] {
        DEB_RELEASED     = 2'd0,
        DEB_PRESS_WAIT   = 2'd1,
        DEB_PRESSED      = 2'd2,
        DEB_RELEASE_WAIT = 2'd3
    } deb_state_t;

    // The push-button pulls the line low while held.
    localparam logic ENT_PRESSED = 1'b0;

    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

endpackage : entry_input_port_pkg
`default_nettype wire

// File: rtl/entry_input_port_if.sv
`default_nettype none
// ============================================================================
// entry_input_port_if : processor-side word handshake of the keyed-input port
// Revision: 1.0
// ============================================================================
interface entry_input_port_if #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]       data;
    logic                   valid;
    logic [$clog2(DEPTH):0] count;
    logic                   overflow;
    logic                   rd;
    logic                   clr_ovf;

    modport master (
        output data, valid, count, overflow,
        input  rd, clr_ovf
    );

    modport slave (
        input  data, valid, count, overflow,
        output rd, clr_ovf
    );
endinterface : entry_input_port_if
`default_nettype wire

// File: rtl/entry_input_port_ent_debouncer.sv
`default_nettype none
// ============================================================================
// entry_input_port_ent_debouncer : ent synchronizer + debounce FSM, one-cycle
// capture pulse on each qualified press-release. Revision: 1.0
// ============================================================================
module entry_input_port_ent_debouncer
    import entry_input_port_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic ent,
    output logic capture
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             ent_meta;
    logic             ent_s;
    deb_state_t       state;
    deb_state_t       state_next;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             capture_next;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ent_meta <= 1'b1;
            ent_s    <= 1'b1;
            state    <= DEB_RELEASED;
            cnt      <= '0;
            capture  <= 1'b0;
        end else begin
            ent_meta <= ent;
            ent_s    <= ent_meta;
            state    <= state_next;
            cnt      <= cnt_next;
            capture  <= capture_next;
        end
    end

    // Counter only advances while waiting; any other outcome restarts it at 0.
    always_comb begin
        state_next = state;
        cnt_next   = '0;
        case (state)
            DEB_RELEASED: begin
                if (ent_s == ENT_PRESSED) state_next = DEB_PRESS_WAIT;
            end
            DEB_PRESS_WAIT: begin
                if (ent_s != ENT_PRESSED)  state_next = DEB_RELEASED;
                else if (cnt == CNT_LAST)  state_next = DEB_PRESSED;
                else                       cnt_next   = cnt + 1'b1;
            end
            DEB_PRESSED: begin
                if (ent_s != ENT_PRESSED) state_next = DEB_RELEASE_WAIT;
            end
            DEB_RELEASE_WAIT: begin
                if (ent_s == ENT_PRESSED)  state_next = DEB_PRESSED;
                else if (cnt == CNT_LAST)  state_next = DEB_RELEASED;
                else                       cnt_next   = cnt + 1'b1;
            end
            default: state_next = DEB_RELEASED;
        endcase
    end

    always_comb begin
        capture_next = (state == DEB_RELEASE_WAIT) && (ent_s != ENT_PRESSED) && (cnt == CNT_LAST);
    end

endmodule : entry_input_port_ent_debouncer
`default_nettype wire

// File: rtl/entry_input_port.sv
`default_nettype none
// ============================================================================
// entry_input_port : debounced switch-word capture into a FIFO presented to
// the processor with a valid/read handshake. Revision: 1.0
// ============================================================================
module entry_input_port
    import entry_input_port_pkg::*;
#(
    parameter int          WIDTH           = 16,
    parameter int          DEPTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ent,
    input  logic [WIDTH-1:0]        switch,
    entry_input_port_if.master      bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [WIDTH-1:0] sw_meta;
    logic [WIDTH-1:0] sw_s;
    logic             capture;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_inc;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] head;
    logic             ovf;

    logic             full;
    logic             pop;
    logic             push;
    logic             drop;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_meta <= '0;
            sw_s    <= '0;
        end else begin
            sw_meta <= switch;
            sw_s    <= sw_meta;
        end
    end

    entry_input_port_ent_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_deb (
        .clk     (clk),
        .reset   (reset),
        .ent     (ent),
        .capture (capture)
    );

    // A full FIFO still accepts a capture when the head is popped that cycle.
    assign full       = (cnt == CNT_FULL);
    assign pop        = bus.rd && (cnt != '0);
    assign push       = capture && (!full || pop);
    assign drop       = capture && full && !pop;
    assign rd_ptr_inc = rd_ptr + 1'b1;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= sw_s;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr_inc;
            case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // Head register tracks mem[rd_ptr]; it is left alone when the FIFO drains.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head <= '0;
        end else if (pop) begin
            if (cnt > CNT_W'(1))  head <= mem[rd_ptr_inc];
            else if (push)        head <= sw_s;
        end else if (push && (cnt == '0)) begin
            head <= sw_s;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)            ovf <= 1'b0;
        else if (drop)         ovf <= 1'b1;
        else if (bus.clr_ovf)  ovf <= 1'b0;
    end

    assign bus.data     = head;
    assign bus.valid    = (cnt != '0);
    assign bus.count    = cnt;
    assign bus.overflow = ovf;

endmodule : entry_input_port
`default_nettype wire

// File: tb/tb_entry_input_port.sv
`default_nettype none
// ============================================================================
// tb_entry_input_port : directed stimulus with a word scoreboard checked on pops
// Revision: 1.0
// ============================================================================
module tb_entry_input_port;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int DEB   = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             ent;
    logic [WIDTH-1:0] switch;

    entry_input_port_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    entry_input_port #(
        .WIDTH           (WIDTH),
        .DEPTH           (DEPTH),
        .DEBOUNCE_CYCLES (DEB)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .ent    (ent),
        .switch (switch),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int               n_cmp = 0;
    int               n_bad = 0;
    int               mcount = 0;
    logic [WIDTH-1:0] exp_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Clean press then release; the word lands in the FIFO 7 edges after release.
    task automatic enter(input logic [WIDTH-1:0] w);
        switch = w;
        ent    = 1'b0;
        tick(10);
        ent    = 1'b1;
        tick(8);
        if (mcount < DEPTH) begin
            exp_q.push_back(w);
            mcount++;
        end
    endtask

    task automatic read1();
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        if (mcount > 0) mcount--;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (reset === 1'b1 && bus.rd === 1'b1 && bus.valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL pop_unexpected: got data %0h, expected no word", bus.data);
            end else begin
                check("pop_data", 32'(bus.data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset       = 1'b0;
        ent         = 1'b0;
        switch      = '0;
        bus.rd      = 1'b0;
        bus.clr_ovf = 1'b0;
        tick(3);
        check("rst_data",     32'(bus.data),     32'h0);
        check("rst_valid",    32'(bus.valid),    32'h0);
        check("rst_count",    32'(bus.count),    32'h0);
        check("rst_overflow", 32'(bus.overflow), 32'h0);

        // ent held through reset, released too soon to qualify as a press
        reset = 1'b1;
        tick(2);
        ent = 1'b1;
        tick(12);
        check("post_rst_no_capture", 32'(bus.count), 32'h0);
        enter(16'h1234);
        check("post_rst_one_word", 32'(bus.count), 32'h1);
        read1();
        check("post_rst_drained", 32'(bus.count), 32'h0);

        // clean entry with exact latency
        switch = 16'hABCD;
        ent    = 1'b0;
        tick(10);
        ent    = 1'b1;
        tick(7);
        check("latency_early_valid", 32'(bus.valid), 32'h0);
        tick(1);
        exp_q.push_back(16'hABCD);
        mcount++;
        check("clean_valid", 32'(bus.valid), 32'h1);
        check("clean_data",  32'(bus.data),  32'hABCD);
        check("clean_count", 32'(bus.count), 32'h1);
        read1();
        check("clean_read_valid", 32'(bus.valid), 32'h0);
        check("clean_read_count", 32'(bus.count), 32'h0);

        // bounce
        switch = 16'hBEEF;
        ent = 1'b0; tick(3);
        ent = 1'b1; tick(2);
        ent = 1'b0; tick(3);
        ent = 1'b1; tick(15);
        check("bounce_count", 32'(bus.count), 32'h0);
        check("bounce_valid", 32'(bus.valid), 32'h0);

        // overflow
        for (int i = 1; i <= 5; i++) enter(WIDTH'(i));
        check("ovf_count", 32'(bus.count),    32'h4);
        check("ovf_data",  32'(bus.data),     32'h1);
        check("ovf_flag",  32'(bus.overflow), 32'h1);
        for (int i = 0; i < 4; i++) read1();
        check("ovf_drain_count", 32'(bus.count), 32'h0);
        check("ovf_drain_valid", 32'(bus.valid), 32'h0);
        check("empty_holds_head", 32'(bus.data), 32'h4);
        bus.clr_ovf = 1'b1;
        tick(1);
        bus.clr_ovf = 1'b0;
        check("ovf_cleared", 32'(bus.overflow), 32'h0);

        // full FIFO with a pop on the capture cycle
        for (int i = 1; i <= 4; i++) enter(WIDTH'(i));
        check("full_count", 32'(bus.count), 32'h4);
        switch = 16'h0009;
        ent    = 1'b0;
        tick(10);
        ent    = 1'b1;
        tick(7);
        bus.rd = 1'b1;
        tick(1);
        bus.rd = 1'b0;
        exp_q.push_back(16'h0009);
        check("simul_count",    32'(bus.count),    32'h4);
        check("simul_overflow", 32'(bus.overflow), 32'h0);
        check("simul_head",     32'(bus.data),     32'h2);
        tick(1);
        for (int i = 0; i < 4; i++) read1();
        mcount = 0;
        check("simul_drain_valid", 32'(bus.valid), 32'h0);

        // reads while empty
        bus.rd = 1'b1;
        tick(3);
        bus.rd = 1'b0;
        check("empty_rd_count", 32'(bus.count), 32'h0);
        check("empty_rd_valid", 32'(bus.valid), 32'h0);
        enter(16'h5A5A);
        check("after_empty_data",  32'(bus.data),  32'h5A5A);
        check("after_empty_count", 32'(bus.count), 32'h1);
        read1();
        check("final_valid", 32'(bus.valid), 32'h0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_entry_input_port
`default_nettype wire
